// File: rtl/contador_secuencia_pkg.sv
// ---------------------------------------------------------------------------
// contador_secuencia_pkg
// Shared constants for the arbitrary-sequence counter:
//   - STATE_W / estado_t : width and type of the counter state
//   - S0..S7             : the sequence members, in index order
//   - PRESCALE_MIN/MAX   : legal range of the prescaler parameter
// ---------------------------------------------------------------------------
package contador_secuencia_pkg;

  localparam int STATE_W = 4;

  typedef logic [STATE_W-1:0] estado_t;

  localparam estado_t S0 = 4'd0;
  localparam estado_t S1 = 4'd3;
  localparam estado_t S2 = 4'd5;
  localparam estado_t S3 = 4'd6;
  localparam estado_t S4 = 4'd9;
  localparam estado_t S5 = 4'd10;
  localparam estado_t S6 = 4'd12;
  localparam estado_t S7 = 4'd15;

  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 16;

endpackage

// File: rtl/contador_secuencia_if.sv
// ---------------------------------------------------------------------------
// contador_secuencia_if
// Control/data bundle of the sequence counter.
//   i_en    : count enable (qualifies prescaler advance)
//   i_up    : 1 = forward through the sequence, 0 = backward
//   i_load  : synchronous load of i_d, overrides i_en
//   i_d     : load value (any 4-bit value)
//   o_q     : counter state
//   o_nq    : registered complement of o_q
//   o_wrap  : one-cycle pulse after a sequence wrap
//   o_fuera : o_q is not a sequence member (combinational)
// master drives the controls, slave is the counter.
// ---------------------------------------------------------------------------
interface contador_secuencia_if;
  import contador_secuencia_pkg::*;

  logic    i_en;
  logic    i_up;
  logic    i_load;
  estado_t i_d;
  estado_t o_q;
  estado_t o_nq;
  logic    o_wrap;
  logic    o_fuera;

  modport master (
    output i_en, i_up, i_load, i_d,
    input  o_q, o_nq, o_wrap, o_fuera
  );

  modport slave (
    input  i_en, i_up, i_load, i_d,
    output o_q, o_nq, o_wrap, o_fuera
  );

endinterface

// File: rtl/contador_secuencia_secuencia_siguiente.sv
// ---------------------------------------------------------------------------
// secuencia_siguiente
// Combinational next-state logic of the sequence counter.
//   i_cur    : current state
//   i_up     : direction (1 = forward, 0 = backward)
//   o_next   : state after one step
//   o_wrap_n : the step from i_cur in direction i_up wraps the sequence
//   o_fuera  : i_cur is not a sequence member
// Out-of-sequence states recover to the smallest member above them,
// independent of direction, and never flag a wrap.
// ---------------------------------------------------------------------------
module secuencia_siguiente
  import contador_secuencia_pkg::*;
(
  input  estado_t i_cur,
  input  logic    i_up,
  output estado_t o_next,
  output logic    o_wrap_n,
  output logic    o_fuera
);

  // Member successor/predecessor lookup plus recovery mapping; all 16
  // encodings are listed so every state has a defined successor.
  always_comb begin
    o_next   = S0;
    o_wrap_n = 1'b0;
    o_fuera  = 1'b0;
    case (i_cur)
      S0: begin
        o_next   = i_up ? S1 : S7;
        o_wrap_n = ~i_up;
      end
      S1: o_next = i_up ? S2 : S0;
      S2: o_next = i_up ? S3 : S1;
      S3: o_next = i_up ? S4 : S2;
      S4: o_next = i_up ? S5 : S3;
      S5: o_next = i_up ? S6 : S4;
      S6: o_next = i_up ? S7 : S5;
      S7: begin
        o_next   = i_up ? S0 : S6;
        o_wrap_n = i_up;
      end
      4'd1, 4'd2: begin
        o_next  = S1;
        o_fuera = 1'b1;
      end
      4'd4: begin
        o_next  = S2;
        o_fuera = 1'b1;
      end
      4'd7, 4'd8: begin
        o_next  = S4;
        o_fuera = 1'b1;
      end
      4'd11: begin
        o_next  = S6;
        o_fuera = 1'b1;
      end
      4'd13, 4'd14: begin
        o_next  = S7;
        o_fuera = 1'b1;
      end
      default: begin
        o_next   = S0;
        o_wrap_n = 1'b0;
        o_fuera  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/contador_secuencia.sv
// ---------------------------------------------------------------------------
// contador_secuencia
// State-register stage of the arbitrary-sequence counter
// (0, 3, 5, 6, 9, 10, 12, 15).
//   PRESCALE : enabled cycles per step, 1..16
//   clk      : rising-edge clock
//   nReset   : asynchronous active-low reset
//   bus      : contador_secuencia_if.slave (controls in, Q/nQ/wrap/fuera out)
// Priority: nReset > load > step > hold.
// ---------------------------------------------------------------------------
module contador_secuencia
  import contador_secuencia_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  nReset,
  contador_secuencia_if.slave   bus
);

  estado_t r_q;
  estado_t r_nq;
  logic    r_wrap;
  logic    w_step;
  estado_t w_next;
  logic    w_wrapN;
  logic    w_fuera;

  secuencia_siguiente u_siguiente (
    .i_cur    (r_q),
    .i_up     (bus.i_up),
    .o_next   (w_next),
    .o_wrap_n (w_wrapN),
    .o_fuera  (w_fuera)
  );

  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_badPrescale
    $error("contador_secuencia: PRESCALE out of range");
  end

  if (PRESCALE == 1) begin : g_noPc
    // Without prescaling every enabled cycle is a step.
    assign w_step = bus.i_en;
  end else begin : g_pc
    localparam int PC_W = $clog2(PRESCALE);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

    logic [PC_W-1:0] r_pc;

    assign w_step = bus.i_en && (r_pc == PC_LAST);

    // Prescaler: load restarts the count so the next step needs a full
    // PRESCALE enabled cycles.
    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        r_pc <= '0;
      end else if (bus.i_load) begin
        r_pc <= '0;
      end else if (bus.i_en) begin
        r_pc <= (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
      end
    end
  end

  // Counter state; nQ is registered from the same source as Q so the two
  // never disagree, and wrap is a single-cycle pulse cleared on every
  // non-step cycle.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_q    <= S0;
      r_nq   <= ~S0;
      r_wrap <= 1'b0;
    end else if (bus.i_load) begin
      r_q    <= bus.i_d;
      r_nq   <= ~bus.i_d;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_q    <= w_next;
      r_nq   <= ~w_next;
      r_wrap <= w_wrapN;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.o_q     = r_q;
  assign bus.o_nq    = r_nq;
  assign bus.o_wrap  = r_wrap;
  assign bus.o_fuera = w_fuera;

endmodule
